// File: rtl/conf_row_loader_if.sv
// conf_row_loader_if: valid/ready port carrying one PE configuration word per beat.
//   data  : configuration word, master -> slave
//   valid : data is valid, master -> slave
//   ready : slave can accept a word, slave -> master
interface conf_row_loader_if #(
    parameter int W_IN = 32
);
    logic [W_IN-1:0] data;
    logic            valid;
    logic            ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/conf_row_loader.sv
// conf_row_loader: packs a stream of per-PE configuration words into a shadow bank and commits it to the active bank on swap.
//   clk, rst            : single clock, synchronous active-high reset
//   in_if (slave)       : word stream; word layout LSB first is SE, SEL_B, SEL_A, ALU
//   swap_i              : array idle, commit a complete shadow bank to the active bank
//   abort_i             : discard a partial or complete shadow load
//   loaded_o            : shadow bank complete, waiting for swap
//   done_o              : one-cycle pulse after the active bank is updated
//   conf_*_o            : active fields, PE i at slice i
//   conf_*_{n,nw,ne}_o  : neighbour views of the active bank for the row below
module conf_row_loader #(
    parameter int N_PE  = 8,
    parameter int W_ALU = 4,
    parameter int W_SEL = 4,
    parameter int W_SE  = 10,
    parameter int W_IN  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    conf_row_loader_if.slave        in_if,
    input  logic                    swap_i,
    input  logic                    abort_i,
    output logic                    loaded_o,
    output logic                    done_o,
    output logic [N_PE*W_ALU-1:0]   conf_alu_o,
    output logic [N_PE*W_SEL-1:0]   conf_sel_a_o,
    output logic [N_PE*W_SEL-1:0]   conf_sel_b_o,
    output logic [N_PE*W_SE-1:0]    conf_se_o,
    output logic [N_PE*W_SEL-1:0]   conf_sel_a_n_o,
    output logic [N_PE*W_SEL-1:0]   conf_sel_a_nw_o,
    output logic [N_PE*W_SEL-1:0]   conf_sel_a_ne_o,
    output logic [N_PE*W_SEL-1:0]   conf_sel_b_n_o,
    output logic [N_PE*W_SEL-1:0]   conf_sel_b_nw_o,
    output logic [N_PE*W_SEL-1:0]   conf_sel_b_ne_o,
    output logic [N_PE*W_SE-1:0]    conf_se_n_o,
    output logic [N_PE*W_SE-1:0]    conf_se_nw_o,
    output logic [N_PE*W_SE-1:0]    conf_se_ne_o
);
    localparam int W_USED = W_SE + 2 * W_SEL + W_ALU;
    localparam int IW     = N_PE > 1 ? $clog2(N_PE) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

    state_t                  state_q;
    logic [IW-1:0]           idx_q;
    logic                    ready_q;
    logic                    loaded_q;
    logic                    done_q;
    logic [N_PE*W_ALU-1:0]   sh_alu_q;
    logic [N_PE*W_SEL-1:0]   sh_sel_a_q;
    logic [N_PE*W_SEL-1:0]   sh_sel_b_q;
    logic [N_PE*W_SE-1:0]    sh_se_q;
    logic [N_PE*W_ALU-1:0]   act_alu_q;
    logic [N_PE*W_SEL-1:0]   act_sel_a_q;
    logic [N_PE*W_SEL-1:0]   act_sel_b_q;
    logic [N_PE*W_SE-1:0]    act_se_q;

    logic [W_ALU-1:0]        w_alu;
    logic [W_SEL-1:0]        w_sel_a;
    logic [W_SEL-1:0]        w_sel_b;
    logic [W_SE-1:0]         w_se;
    logic                    accept;
    logic                    last;

    assign w_se    = in_if.data[W_SE-1:0];
    assign w_sel_b = in_if.data[W_SE +: W_SEL];
    assign w_sel_a = in_if.data[W_SE + W_SEL +: W_SEL];
    assign w_alu   = in_if.data[W_SE + 2 * W_SEL +: W_ALU];

    // Bits above the packed fields carry no configuration.
    if (W_IN > W_USED) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^in_if.data[W_IN-1:W_USED];
    end

    // ready_q is zero only in FULL and in reset, so it doubles as the load-enable.
    assign accept = in_if.valid & ready_q;
    assign last   = idx_q == IW'(N_PE - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            ready_q     <= 1'b0;
            loaded_q    <= 1'b0;
            done_q      <= 1'b0;
            sh_alu_q    <= '0;
            sh_sel_a_q  <= '0;
            sh_sel_b_q  <= '0;
            sh_se_q     <= '0;
            act_alu_q   <= '0;
            act_sel_a_q <= '0;
            act_sel_b_q <= '0;
            act_se_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, LOAD: begin
                    ready_q <= 1'b1;
                    // Abort outranks a word accepted in the same cycle; the word is dropped.
                    if (abort_i && state_q == LOAD) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                    end else if (accept) begin
                        sh_alu_q[idx_q*W_ALU +: W_ALU]   <= w_alu;
                        sh_sel_a_q[idx_q*W_SEL +: W_SEL] <= w_sel_a;
                        sh_sel_b_q[idx_q*W_SEL +: W_SEL] <= w_sel_b;
                        sh_se_q[idx_q*W_SE +: W_SE]      <= w_se;
                        if (last) begin
                            state_q  <= FULL;
                            idx_q    <= '0;
                            ready_q  <= 1'b0;
                            loaded_q <= 1'b1;
                        end else begin
                            state_q <= LOAD;
                            idx_q   <= idx_q + IW'(1);
                        end
                    end
                end
                FULL: begin
                    // Abort outranks swap so the active bank is left untouched.
                    if (abort_i) begin
                        state_q  <= IDLE;
                        idx_q    <= '0;
                        ready_q  <= 1'b1;
                        loaded_q <= 1'b0;
                    end else if (swap_i) begin
                        state_q     <= IDLE;
                        ready_q     <= 1'b1;
                        loaded_q    <= 1'b0;
                        done_q      <= 1'b1;
                        act_alu_q   <= sh_alu_q;
                        act_sel_a_q <= sh_sel_a_q;
                        act_sel_b_q <= sh_sel_b_q;
                        act_se_q    <= sh_se_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    assign in_if.ready  = ready_q;
    assign loaded_o     = loaded_q;
    assign done_o       = done_q;
    assign conf_alu_o   = act_alu_q;
    assign conf_sel_a_o = act_sel_a_q;
    assign conf_sel_b_o = act_sel_b_q;
    assign conf_se_o    = act_se_q;

    assign conf_sel_a_n_o = act_sel_a_q;
    assign conf_sel_b_n_o = act_sel_b_q;
    assign conf_se_n_o    = act_se_q;

    // Diagonal views shift the active bank by one column; edge columns read
    // as zero, which the row below treats as "no delay-line consumer".
    for (genvar i = 0; i < N_PE; i++) begin : g_col
        if (i == 0) begin : g_w
            assign conf_sel_a_nw_o[i*W_SEL +: W_SEL] = '0;
            assign conf_sel_b_nw_o[i*W_SEL +: W_SEL] = '0;
            assign conf_se_nw_o[i*W_SE +: W_SE]      = '0;
        end else begin : g_w
            assign conf_sel_a_nw_o[i*W_SEL +: W_SEL] = act_sel_a_q[(i-1)*W_SEL +: W_SEL];
            assign conf_sel_b_nw_o[i*W_SEL +: W_SEL] = act_sel_b_q[(i-1)*W_SEL +: W_SEL];
            assign conf_se_nw_o[i*W_SE +: W_SE]      = act_se_q[(i-1)*W_SE +: W_SE];
        end
        if (i == N_PE - 1) begin : g_e
            assign conf_sel_a_ne_o[i*W_SEL +: W_SEL] = '0;
            assign conf_sel_b_ne_o[i*W_SEL +: W_SEL] = '0;
            assign conf_se_ne_o[i*W_SE +: W_SE]      = '0;
        end else begin : g_e
            assign conf_sel_a_ne_o[i*W_SEL +: W_SEL] = act_sel_a_q[(i+1)*W_SEL +: W_SEL];
            assign conf_sel_b_ne_o[i*W_SEL +: W_SEL] = act_sel_b_q[(i+1)*W_SEL +: W_SEL];
            assign conf_se_ne_o[i*W_SE +: W_SE]      = act_se_q[(i+1)*W_SE +: W_SE];
        end
    end
endmodule
